// File: rtl/lru_pkg.sv
// Shared types and the recency-order touch helper for the four-item LRU queue.
package lru_pkg;

    localparam int unsigned N_ITEMS = 4;
    localparam int unsigned IDX_W   = $clog2(N_ITEMS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef idx_t [N_ITEMS-1:0] order_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COMMIT
    } state_t;

    // Entry 0 is MRU, entry N_ITEMS-1 is LRU.
    localparam order_t ORDER_RST = {idx_t'(3), idx_t'(2), idx_t'(1), idx_t'(0)};

    // Move item k to MRU, shifting the entries that were more recent down by one.
    function automatic order_t touch(input order_t o, input idx_t k);
        order_t r;
        logic   found;
        r     = o;
        found = (o[0] == k);
        for (int unsigned i = 1; i < N_ITEMS; i++) begin
            if (!found) begin
                r[i]  = o[i-1];
                found = (o[i] == k);
            end
        end
        r[0] = k;
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button front end: two-flop synchroniser then tick-sampled rising-edge detect.
module btn_edge
    import lru_pkg::*;
#(
    parameter int unsigned W = N_ITEMS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] press_c
);

    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            if (tick) begin
                prev_q <= sync2_q;
            end
        end
    end

    // A held button yields one press because prev only advances on tick.
    assign press_c = tick ? (sync2_q & ~prev_q) : '0;

endmodule

// File: rtl/lru_victim.sv
// LRU victim server: tracks recency of four items, grants the LRU via req/ack,
// then promotes the evicted item to MRU.
module lru_victim
    import lru_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             b1,
    input  logic             b2,
    input  logic             b3,
    input  logic             b4,
    input  logic             evict_req,
    input  logic             evict_ack,
    output logic             victim_valid,
    output logic [IDX_W-1:0] victim_idx,
    output logic             l1,
    output logic             l2,
    output logic             l3,
    output logic             l4
);

    localparam logic [N_ITEMS-1:0] LED_RST = {1'b1, {(N_ITEMS-1){1'b0}}};

    logic [N_ITEMS-1:0] press_c;
    logic [N_ITEMS-1:0] pending_q, pending_d;
    logic [N_ITEMS-1:0] led_q, led_d;
    logic [N_ITEMS-1:0] clr_c;
    order_t             order_q, order_d;
    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    idx_t               vidx_q, vidx_d;
    idx_t               pick_c;
    logic               pick_found_c;

    btn_edge #(.W(N_ITEMS)) u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .btn_i   ({b4, b3, b2, b1}),
        .press_c (press_c)
    );

    // Lowest-index pending item.
    always_comb begin
        pick_c       = '0;
        pick_found_c = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (!pick_found_c && pending_q[i]) begin
                pick_c       = idx_t'(i);
                pick_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        order_d = order_q;
        valid_d = valid_q;
        vidx_d  = vidx_q;
        clr_c   = '0;
        led_d   = '0;
        led_d[order_q[N_ITEMS-1]] = 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    order_d        = touch(order_q, pick_c);
                    clr_c[pick_c]  = 1'b1;
                end else if (evict_req) begin
                    vidx_d  = order_q[N_ITEMS-1];
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (evict_ack) begin
                    valid_d = 1'b0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                order_d = touch(order_q, vidx_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A press landing on the cycle its bit is consumed merges into that touch.
        pending_d = (pending_q | press_c) & ~clr_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            order_q   <= ORDER_RST;
            pending_q <= '0;
            valid_q   <= 1'b0;
            vidx_q    <= idx_t'(N_ITEMS - 1);
            led_q     <= LED_RST;
        end else begin
            state_q   <= state_d;
            order_q   <= order_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            vidx_q    <= vidx_d;
            led_q     <= led_d;
        end
    end

    assign victim_valid = valid_q;
    assign victim_idx   = vidx_q;
    assign l1           = led_q[0];
    assign l2           = led_q[1];
    assign l3           = led_q[2];
    assign l4           = led_q[3];

endmodule

// File: tb/tb_lru_victim.sv
// Bench for lru_victim: queue-based recency model checked every cycle, plus
// directed scenarios with hand-computed orders and LED patterns.
module tb_lru_victim;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] btn;
    logic       evict_req;
    logic       evict_ack;
    logic       victim_valid;
    logic [1:0] victim_idx;
    logic       l1, l2, l3, l4;

    int tests = 0;
    int fails = 0;

    lru_victim dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .b1           (btn[0]),
        .b2           (btn[1]),
        .b3           (btn[2]),
        .b4           (btn[3]),
        .evict_req    (evict_req),
        .evict_ack    (evict_ack),
        .victim_valid (victim_valid),
        .victim_idx   (victim_idx),
        .l1           (l1),
        .l2           (l2),
        .l3           (l3),
        .l4           (l4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q[$];          // q[0] = MRU ... q[3] = LRU
    int m_s1, m_s2, m_prev, m_pend, m_mode, m_vidx, m_led, m_press, m_clr, m_k;
    bit m_vvalid;

    function automatic int enc(input int a, input int b, input int c, input int d);
        return (a << 6) | (b << 4) | (c << 2) | d;
    endfunction

    function automatic int qcode();
        return enc(q[0], q[1], q[2], q[3]);
    endfunction

    task automatic m_touch(input int k);
        foreach (q[i]) begin
            if (q[i] == k) begin
                q.delete(i);
                break;
            end
        end
        q.push_front(k);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q        = '{0, 1, 2, 3};
            m_s1     = 0;
            m_s2     = 0;
            m_prev   = 0;
            m_pend   = 0;
            m_mode   = 0;
            m_vidx   = 3;
            m_vvalid = 1'b0;
            m_led    = 3;
        end else begin
            m_press = tick ? (m_s2 & ~m_prev & 15) : 0;
            if (tick) m_prev = m_s2;
            m_s2  = m_s1;
            m_s1  = int'(btn);
            m_led = q[3];
            m_clr = 0;
            if (m_mode == 0) begin
                if (m_pend != 0) begin
                    m_k = 0;
                    while (((m_pend >> m_k) & 1) == 0) m_k++;
                    m_touch(m_k);
                    m_clr = 1 << m_k;
                end else if (evict_req) begin
                    m_vidx   = q[3];
                    m_vvalid = 1'b1;
                    m_mode   = 1;
                end
            end else if (m_mode == 1) begin
                if (evict_ack) begin
                    m_vvalid = 1'b0;
                    m_mode   = 2;
                end
            end else begin
                m_touch(m_vidx);
                m_mode = 0;
            end
            m_pend = (m_pend | m_press) & ~m_clr;
        end
    end

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("cyc_valid", int'(victim_valid), int'(m_vvalid));
            chk("cyc_idx", int'(victim_idx), m_vidx);
            chk("cyc_leds", int'({l4, l3, l2, l1}), 1 << m_led);
        end
    end

    // ---------------- stimulus ----------------
    int tcnt = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            tick = (tcnt % 4 == 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        @(negedge clk);
        btn = m;
        repeat (12) @(negedge clk);
        btn = 4'b0000;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        btn       = 4'b0000;
        evict_req = 1'b0;
        evict_ack = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(victim_valid), 0);
        chk("rst_idx", int'(victim_idx), 3);
        chk("rst_leds", int'({l4, l3, l2, l1}), 8);
        chk("rst_order_model", qcode(), enc(0, 1, 2, 3));
        rst = 1'b1;
        @(negedge clk);

        // b2, b4, b1 in turn -> {0,3,1,2}, LRU item 2
        press(4'b0010);
        press(4'b1000);
        press(4'b0001);
        chk("seq_order", qcode(), enc(0, 3, 1, 2));
        chk("seq_leds", int'({l4, l3, l2, l1}), 4);

        // Eviction from reset
        do_reset();
        evict_req = 1'b1;
        @(negedge clk);
        chk("grant_valid", int'(victim_valid), 1);
        chk("grant_idx", int'(victim_idx), 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(victim_valid), 1);
            chk("hold_idx", int'(victim_idx), 3);
        end
        evict_ack = 1'b1;
        @(negedge clk);
        chk("ack_drop", int'(victim_valid), 0);
        evict_ack = 1'b0;
        evict_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("commit_order", qcode(), enc(3, 0, 1, 2));
        chk("commit_leds", int'({l4, l3, l2, l1}), 4);
        evict_req = 1'b1;
        @(negedge clk);
        chk("grant2_valid", int'(victim_valid), 1);
        chk("grant2_idx", int'(victim_idx), 2);
        evict_ack = 1'b1;
        @(negedge clk);
        evict_ack = 1'b0;
        evict_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("order_after2", qcode(), enc(2, 3, 0, 1));

        // b1 press during GRANT: victim touched first, then item 0
        evict_req = 1'b1;
        @(negedge clk);
        chk("grant3_idx", int'(victim_idx), 1);
        btn = 4'b0001;
        repeat (12) @(negedge clk);
        btn = 4'b0000;
        repeat (12) @(negedge clk);
        chk("defer_valid", int'(victim_valid), 1);
        chk("defer_order", qcode(), enc(2, 3, 0, 1));
        chk("defer_leds", int'({l4, l3, l2, l1}), 2);
        evict_ack = 1'b1;
        @(negedge clk);
        evict_ack = 1'b0;
        evict_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("defer_final", qcode(), enc(0, 1, 2, 3));
        chk("defer_final_leds", int'({l4, l3, l2, l1}), 8);

        // b1 and b3 on the same tick
        do_reset();
        press(4'b0101);
        chk("dual_order", qcode(), enc(2, 0, 1, 3));
        chk("dual_leds", int'({l4, l3, l2, l1}), 8);

        // Reset during GRANT with a pending press
        do_reset();
        evict_req = 1'b1;
        @(negedge clk);
        btn = 4'b1000;
        repeat (12) @(negedge clk);
        btn = 4'b0000;
        repeat (2) @(negedge clk);
        chk("pend_set", m_pend, 8);
        chk("pre_rst_valid", int'(victim_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", int'(victim_valid), 0);
        chk("midrst_idx", int'(victim_idx), 3);
        chk("midrst_leds", int'({l4, l3, l2, l1}), 8);
        evict_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_leds", int'({l4, l3, l2, l1}), 8);
        chk("post_rst_valid", int'(victim_valid), 0);
        chk("post_rst_pend", m_pend, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lru_victim.md
# lru_victim

Recency tracker for the four-button panel that supplies the least-recently-used item, the eviction side of the LRU queue. It keeps a full recency order of items 0..3 (buttons b1..b4) and drives the LRU item onto one-hot LEDs. It serves the LRU index to a consumer through a req/ack handshake, then promotes the evicted item to most-recent. Buttons are sampled on the panel tick from the shared timer, so timing matches the existing LRU display.

## Interface
- N_ITEMS, 4, number of tracked items; only 4 is supported.
- IDX_W, 2, item index width, $clog2(N_ITEMS).

- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle sample strobe from the timer.
- b1, b2, b3, b4  in  1 each  raw button levels (asynchronous).
- evict_req  in  1  level request for a victim.
- evict_ack  in  1  consumer accepts the presented victim.
- victim_valid  out  1  victim_idx is valid and held.
- victim_idx  out  IDX_W  current LRU item.
- l1, l2, l3, l4  out  1 each  one-hot LRU indicator; l1 = item 0.

## Operation
- Order register order[0..3] (IDX_W each): order[0] = MRU, order[3] = LRU. It is always a permutation of 0..3.
  - Reset value: {0,1,2,3}, so the LRU is item 3.
- Button front end: each b is synchronised by 2 flops and sampled only when tick=1.
  - press_k = sampled_k & ~prev_sampled_k. prev updates only on tick.
  - A press sets pending[k]. A held button produces one press only.
- Touch item k: find position p where order[p]==k. Set order[1..p] = old order[0..p-1] and order[0] = k. Entries above p are unchanged. Touching the current MRU is a no-op.
- FSM states: IDLE, GRANT, COMMIT.
  - IDLE, pending ≠ 0: touch the lowest-index pending item and clear its bit. One touch per cycle. Stay in IDLE.
  - IDLE, pending == 0 and evict_req=1: latch victim_idx = order[3], assert victim_valid, go to GRANT.
  - GRANT: victim_idx and victim_valid are held stable. Touches are deferred; presses still accumulate in pending. On evict_ack=1, deassert victim_valid and go to COMMIT. Dropping evict_req without ack is illegal; the FSM holds GRANT.
  - COMMIT: touch victim_idx, then go to IDLE.
- Pending has priority over evict_req in IDLE, so the victim always reflects all accepted presses.
- A press edge coinciding with a pending bit already set for the same item merges into that bit.
- LEDs and victim_idx are registered. l1..l4 = onehot(order[3]), updated the cycle after order changes.
- Reset values: order {0,1,2,3}, pending 0, state IDLE, victim_valid 0, victim_idx 3, l1=l2=l3=0, l4=1.
- Asserting rst mid-GRANT drops victim_valid immediately and discards pending.

## Timing
- Button to pending: 2 sync cycles, then the next tick edge. Pending to order update: 1 cycle. Order to LED: 1 cycle.
- evict_req in IDLE with no pending: victim_valid rises 1 cycle later.
- Ack to next request: victim_valid falls on the edge that samples ack. The order update happens in COMMIT, 1 cycle later. The earliest next grant is 2 cycles after COMMIT, once the LEDs are updated.
- Worst case with 4 simultaneous presses: 4 consecutive touch cycles before a grant.

## Structure
- Package lru_pkg:
  - N_ITEMS and IDX_W constants.
  - typedef idx_t.
  - typedef order_t (packed array [N_ITEMS] of idx_t).
  - enum state_t {IDLE, GRANT, COMMIT}.
  - Function touch(order_t, idx_t) returning order_t; it is shared with the LRU display block.
- Sub-module btn_edge: 2-flop synchroniser plus tick-sampled rising-edge detector, N_ITEMS bits wide, with the same clk/rst.
- lru_victim holds the FSM, pending mask, order register and output registers.

## Test plan
- Reset: hold rst=0, then release. Required: l4=1, l1..l3=0, victim_idx=3, victim_valid=0, order {0,1,2,3}.
- Press b2, then b4, then b1, each across its own tick. Required: order {0,3,1,2} and l3=1 (LRU is item 2).
- evict_req=1 from reset. Required:
  - victim_valid=1 with idx 3 one cycle later.
  - With ack held low for 5 cycles, idx and valid stay stable.
  - On ack, valid drops; after COMMIT the order is {3,0,1,2}, l3=1, and the next grant gives idx 2.
- b1 press during GRANT. Required: the order is unchanged until ack; COMMIT touches the victim first, then IDLE touches item 0. Final MRU is item 0.
- b1 and b3 rise on the same tick. Required: item 0 touched, then item 2 on the next cycle. Final order {2,0,1,3}, l4=1.
- rst pulsed low during GRANT with pending set. Required: victim_valid=0 immediately and all reset values restored; pending is empty afterwards.
